// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between the control FSM (req0) and the branch unit (req1).
// Latency: a legal op is accepted -> rsp valid after EXEC_CYCLES+1 cycles; an illegal op -> rsp valid after 1 cycle.
// Backpressure: one op in flight; requests are refused outside IDLE and the response holds until its owner's rsp ready.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_negative,
  output logic             rsp_overflow,
  output logic             rsp_less_than,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  input  logic             alu_less_than,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             last_grant;
  logic [3:0]       cnt;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;
  logic             owner_rsp_ready;

  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1000,
      4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111: legal_op = 1'b1;
      default:                                      legal_op = 1'b0;
    endcase
  endfunction

  // Round-robin grant: contention goes to whoever did not win last; only offered in IDLE.
  always_comb begin
    grant0          = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    grant1          = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    accept          = grant0 || grant1;
    sel_op          = grant1 ? req1_op : req0_op;
    sel_a           = grant1 ? req1_a  : req0_a;
    sel_b           = grant1 ? req1_b  : req0_b;
    sel_legal       = legal_op(sel_op);
    owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: illegal ops skip EXEC and answer with an error straight away.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)          state_nxt = sel_legal ? EXEC : RESP;
      EXEC: if (cnt == 4'd0)     state_nxt = RESP;
      RESP: if (owner_rsp_ready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state and owner.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
    busy       = (state != IDLE);
  end

  // Operand latch on accept, settle countdown, and masked result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= 4'd0;
      alu_src_a     <= '0;
      alu_src_b     <= '0;
      alu_control   <= OP_ADD;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_negative  <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_less_than <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant1;
            last_grant <= grant1;
            if (sel_legal) begin
              alu_src_a   <= sel_a;
              alu_src_b   <= sel_b;
              alu_control <= sel_op;
              cnt         <= CNT_INIT;
            end else begin
              rsp_result    <= '0;
              rsp_zero      <= 1'b0;
              rsp_negative  <= 1'b0;
              rsp_overflow  <= 1'b0;
              rsp_less_than <= 1'b0;
              rsp_err       <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result    <= alu_result;
            rsp_zero      <= alu_zero;
            rsp_negative  <= alu_negative;
            // The ALU only defines these flags for the ops that produce them.
            rsp_overflow  <= alu_overflow &&
                             ((alu_control == OP_ADD) || (alu_control == OP_SUB));
            rsp_less_than <= alu_less_than &&
                             ((alu_control == OP_SLT) || (alu_control == OP_SLTU));
            rsp_err       <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
